// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: scoreboard hazard checks, unit start strobes and a
// fixed-latency writeback schedule delivering one result per cycle.
module fpu_issue_ctrl #(
    parameter int LAT_ADD       = 3,
    parameter int LAT_MUL       = 2,
    parameter int LAT_DIV       = 12,
    parameter int LAT_ITOF      = 2,
    parameter int LAT_CMP       = 1,
    parameter int MAX_LAT       = 16,
    parameter int DIV_PIPELINED = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_fd,
    input  logic [4:0]  req_fs,
    input  logic [4:0]  req_ft,
    output logic        issue_add,
    output logic        issue_mul,
    output logic        issue_div,
    output logic        issue_itof,
    output logic        issue_cmp,
    output logic        sub_sel,
    input  logic [31:0] add_res,
    input  logic [31:0] mul_res,
    input  logic [31:0] div_res,
    input  logic [31:0] itof_res,
    input  logic        cmp_res,
    output logic        wb_valid,
    output logic        wb_cond,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] fbusy,
    output logic [7:0]  cbusy,
    output logic        idle,
    output logic        err
);

    localparam int LW = $clog2(MAX_LAT + 1);

    localparam logic [2:0] U_ADD  = 3'd0;
    localparam logic [2:0] U_MUL  = 3'd1;
    localparam logic [2:0] U_DIV  = 3'd2;
    localparam logic [2:0] U_ITOF = 3'd3;
    localparam logic [2:0] U_CMP  = 3'd4;

    // Slot k holds the op that writes back k cycles from now; slot 0 is the head.
    logic [MAX_LAT:0] r_v;
    logic [MAX_LAT:0] r_cnd;
    logic [2:0]       r_unit [MAX_LAT:0];
    logic [4:0]       r_rd   [MAX_LAT:0];
    logic [31:0]      r_fbusy;
    logic [7:0]       r_cbusy;
    logic             r_div_busy;
    logic             r_err;

    logic          w_legal;
    logic          w_src;
    logic [2:0]    w_unit;
    logic [LW-1:0] w_lat;
    logic [LW-1:0] w_ins;
    logic          w_is_div;
    logic          w_is_cmp;
    logic          w_src_hz;
    logic          w_dst_hz;
    logic          w_coll;
    logic          w_div_hz;
    logic          w_acc;
    logic [31:0]   w_fset;
    logic [31:0]   w_fclr;
    logic [7:0]    w_cset;
    logic [7:0]    w_cclr;

    always_comb begin
        w_legal = 1'b1;
        w_src   = 1'b0;
        w_unit  = U_ADD;
        w_lat   = '0;
        unique case (req_op)
            3'd0, 3'd1: begin
                w_unit = U_ADD;
                w_lat  = LW'(LAT_ADD);
                w_src  = 1'b1;
            end
            3'd2: begin
                w_unit = U_MUL;
                w_lat  = LW'(LAT_MUL);
                w_src  = 1'b1;
            end
            3'd3: begin
                w_unit = U_DIV;
                w_lat  = LW'(LAT_DIV);
                w_src  = 1'b1;
            end
            3'd4: begin
                w_unit = U_ITOF;
                w_lat  = LW'(LAT_ITOF);
            end
            3'd5: begin
                w_unit = U_CMP;
                w_lat  = LW'(LAT_CMP);
                w_src  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_is_div = w_legal & (w_unit == U_DIV);
    assign w_is_cmp = w_legal & (w_unit == U_CMP);
    assign w_src_hz = w_src & (r_fbusy[req_fs] | r_fbusy[req_ft]);
    assign w_dst_hz = w_legal &
                      (w_is_cmp ? r_cbusy[req_fd[2:0]] : r_fbusy[req_fd]);
    assign w_coll   = w_legal & r_v[w_lat];
    assign w_div_hz = w_is_div & (DIV_PIPELINED == 0) & r_div_busy;
    assign w_ins    = w_lat - LW'(1);

    // Gating with RST_N keeps strobes quiet while reset is held.
    assign req_ready = RST_N & ~(w_src_hz | w_dst_hz | w_coll | w_div_hz);
    assign w_acc     = req_valid & req_ready;

    assign issue_add  = w_acc & w_legal & (w_unit == U_ADD);
    assign issue_mul  = w_acc & w_legal & (w_unit == U_MUL);
    assign issue_div  = w_acc & w_is_div;
    assign issue_itof = w_acc & w_legal & (w_unit == U_ITOF);
    assign issue_cmp  = w_acc & w_is_cmp;
    assign sub_sel    = issue_add & (req_op == 3'd1);

    assign wb_valid = r_v[0];
    assign wb_cond  = r_v[0] & r_cnd[0];
    assign wb_rd    = r_v[0] ? r_rd[0] : 5'd0;

    always_comb begin
        wb_data = '0;
        if (r_v[0]) begin
            unique case (r_unit[0])
                U_ADD:   wb_data = add_res;
                U_MUL:   wb_data = mul_res;
                U_DIV:   wb_data = div_res;
                U_ITOF:  wb_data = itof_res;
                U_CMP:   wb_data = {31'b0, cmp_res};
                default: wb_data = '0;
            endcase
        end
    end

    assign w_fset = (w_acc & w_legal & ~w_is_cmp) ? (32'd1 << req_fd) : '0;
    assign w_fclr = (r_v[0] & ~r_cnd[0]) ? (32'd1 << r_rd[0]) : '0;
    assign w_cset = (w_acc & w_is_cmp) ? (8'd1 << req_fd[2:0]) : '0;
    assign w_cclr = (r_v[0] & r_cnd[0]) ? (8'd1 << r_rd[0][2:0]) : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_v   <= '0;
            r_cnd <= '0;
            for (int i = 0; i <= MAX_LAT; i++) begin
                r_unit[i] <= U_ADD;
                r_rd[i]   <= '0;
            end
        end else begin
            r_v   <= {1'b0, r_v[MAX_LAT:1]};
            r_cnd <= {1'b0, r_cnd[MAX_LAT:1]};
            for (int i = 0; i < MAX_LAT; i++) begin
                r_unit[i] <= r_unit[i+1];
                r_rd[i]   <= r_rd[i+1];
            end
            if (w_acc & w_legal) begin
                r_v[w_ins]    <= 1'b1;
                r_cnd[w_ins]  <= w_is_cmp;
                r_unit[w_ins] <= w_unit;
                r_rd[w_ins]   <= req_fd;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fbusy    <= '0;
            r_cbusy    <= '0;
            r_div_busy <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_fbusy <= (r_fbusy & ~w_fclr) | w_fset;
            r_cbusy <= (r_cbusy & ~w_cclr) | w_cset;
            r_err   <= r_err | (w_acc & ~w_legal);
            if (w_acc & w_is_div & (DIV_PIPELINED == 0))
                r_div_busy <= 1'b1;
            else if (r_v[0] & (r_unit[0] == U_DIV))
                r_div_busy <= 1'b0;
        end
    end

    assign fbusy = r_fbusy;
    assign cbusy = r_cbusy;
    assign idle  = ~(|r_v) & ~r_div_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus random traffic checked
// against a list-of-in-flight-ops reference model.
module tb_fpu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [4:0]  req_fd = '0, req_fs = '0, req_ft = '0;
    logic        issue_add, issue_mul, issue_div, issue_itof, issue_cmp;
    logic        sub_sel;
    logic [31:0] add_res = '0, mul_res = '0, div_res = '0, itof_res = '0;
    logic        cmp_res = 1'b0;
    logic        wb_valid, wb_cond;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] fbusy;
    logic [7:0]  cbusy;
    logic        idle, err;

    int n_vec = 0;
    int n_bad = 0;

    fpu_issue_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_fd(req_fd), .req_fs(req_fs), .req_ft(req_ft),
        .issue_add(issue_add), .issue_mul(issue_mul),
        .issue_div(issue_div), .issue_itof(issue_itof),
        .issue_cmp(issue_cmp), .sub_sel(sub_sel),
        .add_res(add_res), .mul_res(mul_res), .div_res(div_res),
        .itof_res(itof_res), .cmp_res(cmp_res),
        .wb_valid(wb_valid), .wb_cond(wb_cond), .wb_rd(wb_rd),
        .wb_data(wb_data), .fbusy(fbusy), .cbusy(cbusy),
        .idle(idle), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] strb();
        return {issue_add, issue_mul, issue_div, issue_itof, issue_cmp, sub_sel};
    endfunction

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic req(input logic v, input logic [2:0] op,
                       input logic [4:0] fd, input logic [4:0] fs,
                       input logic [4:0] ft);
        req_valid = v;
        req_op    = op;
        req_fd    = fd;
        req_fs    = fs;
        req_ft    = ft;
        add_res   = $urandom;
        mul_res   = $urandom;
        div_res   = $urandom;
        itof_res  = $urandom;
        cmp_res   = 1'($urandom);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req(1'b1, 3'd0, 5'd3, 5'd1, 5'd2);
        smp();
        n_vec++;
        if (strb() !== 6'b0) begin
            n_bad++; $display("FAIL rst_strobe got %b want 0", strb());
        end
        n_vec++;
        if ({wb_valid, wb_cond, wb_rd, wb_data} !== 39'b0) begin
            n_bad++; $display("FAIL rst_wb got %b %b %h %h want 0",
                              wb_valid, wb_cond, wb_rd, wb_data);
        end
        n_vec++;
        if ({fbusy, cbusy, idle, err} !== {40'b0, 2'b10}) begin
            n_bad++; $display("FAIL rst_state fb=%h cb=%h idle=%b err=%b",
                              fbusy, cbusy, idle, err);
        end
        nxt();
        RST_N = 1'b1;
        req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        smp();
        n_vec++;
        if ({req_ready, idle, wb_valid} !== 3'b110) begin
            n_bad++; $display("FAIL rst_release rdy=%b idle=%b wbv=%b want 1 1 0",
                              req_ready, idle, wb_valid);
        end
    endtask

    task automatic test_basic_add();
        nxt();
        req(1'b1, 3'd0, 5'd3, 5'd1, 5'd2);
        smp();
        n_vec++;
        if ({req_ready, strb()} !== 7'b1100000) begin
            n_bad++; $display("FAIL add_issue got %b want 1100000", {req_ready, strb()});
        end
        for (int k = 1; k <= 4; k++) begin
            nxt();
            req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
            smp();
            n_vec++;
            if (fbusy[3] !== (k <= 3)) begin
                n_bad++; $display("FAIL add_fbusy k=%0d got %b", k, fbusy[3]);
            end
            n_vec++;
            if (wb_valid !== (k == 3)) begin
                n_bad++; $display("FAIL add_wbv k=%0d got %b", k, wb_valid);
            end
            if (k == 3) begin
                n_vec++;
                if ({wb_rd, wb_data} !== {5'd3, add_res}) begin
                    n_bad++; $display("FAIL add_wb got %0d %h want 3 %h",
                                      wb_rd, wb_data, add_res);
                end
            end
        end
    endtask

    task automatic test_raw();
        nxt();
        req(1'b1, 3'd2, 5'd4, 5'd0, 5'd0);
        smp();
        n_vec++;
        if (strb() !== 6'b010000) begin
            n_bad++; $display("FAIL raw_mul got %b want 010000", strb());
        end
        for (int k = 1; k <= 6; k++) begin
            nxt();
            if (k <= 3) req(1'b1, 3'd0, 5'd7, 5'd4, 5'd1);
            else req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
            smp();
            if (k <= 3) begin
                n_vec++;
                if ({req_ready, issue_add} !== {2{k == 3}}) begin
                    n_bad++; $display("FAIL raw_stall k=%0d got %b", k, {req_ready, issue_add});
                end
            end
            if (k == 2 || k == 6) begin
                n_vec++;
                if ({wb_valid, wb_rd} !== {1'b1, (k == 2) ? 5'd4 : 5'd7}) begin
                    n_bad++; $display("FAIL raw_wb k=%0d got %b %0d", k, wb_valid, wb_rd);
                end
            end
        end
    endtask

    task automatic test_collision();
        nxt();
        req(1'b1, 3'd0, 5'd8, 5'd1, 5'd2);
        smp();
        n_vec++;
        if (issue_add !== 1'b1) begin
            n_bad++; $display("FAIL col_add got %b want 1", issue_add);
        end
        for (int k = 1; k <= 4; k++) begin
            nxt();
            if (k <= 2) req(1'b1, 3'd2, 5'd9, 5'd1, 5'd2);
            else req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
            smp();
            if (k <= 2) begin
                n_vec++;
                if ({req_ready, issue_mul} !== {2{k == 2}}) begin
                    n_bad++; $display("FAIL col_stall k=%0d got %b", k, {req_ready, issue_mul});
                end
            end
            if (k == 3) begin
                n_vec++;
                if ({wb_valid, wb_rd} !== {1'b1, 5'd8}) begin
                    n_bad++; $display("FAIL col_wb_add got %b %0d want 1 8", wb_valid, wb_rd);
                end
            end
            if (k == 4) begin
                n_vec++;
                if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, mul_res}) begin
                    n_bad++; $display("FAIL col_wb_mul got %b %0d %h want 1 9 %h",
                                      wb_valid, wb_rd, wb_data, mul_res);
                end
            end
        end
    endtask

    task automatic test_div();
        nxt();
        req(1'b1, 3'd3, 5'd5, 5'd1, 5'd2);
        smp();
        n_vec++;
        if (strb() !== 6'b001000) begin
            n_bad++; $display("FAIL div_issue got %b want 001000", strb());
        end
        for (int k = 1; k <= 25; k++) begin
            nxt();
            if (k <= 13) req(1'b1, 3'd3, 5'd6, 5'd1, 5'd2);
            else req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
            smp();
            if (k <= 13) begin
                n_vec++;
                if ({req_ready, issue_div} !== {2{k == 13}}) begin
                    n_bad++; $display("FAIL div_stall k=%0d got %b", k, {req_ready, issue_div});
                end
            end
            if (k == 12 || k == 25) begin
                n_vec++;
                if ({wb_valid, wb_rd, wb_data} !==
                    {1'b1, (k == 12) ? 5'd5 : 5'd6, div_res}) begin
                    n_bad++; $display("FAIL div_wb k=%0d got %b %0d %h", k,
                                      wb_valid, wb_rd, wb_data);
                end
            end
        end
    endtask

    task automatic test_cmp_illegal();
        nxt();
        req(1'b1, 3'd5, 5'd2, 5'd1, 5'd2);
        smp();
        n_vec++;
        if (strb() !== 6'b000010) begin
            n_bad++; $display("FAIL cmp_issue got %b want 000010", strb());
        end
        nxt();
        req(1'b1, 3'd7, 5'd0, 5'd0, 5'd0);
        smp();
        n_vec++;
        if ({cbusy[2], wb_valid, wb_cond, wb_rd[2:0], wb_data} !==
            {3'b111, 3'd2, 31'b0, cmp_res}) begin
            n_bad++; $display("FAIL cmp_wb got cb=%b v=%b c=%b rd=%0d d=%h",
                              cbusy[2], wb_valid, wb_cond, wb_rd, wb_data);
        end
        n_vec++;
        if ({req_ready, strb()} !== 7'b1000000) begin
            n_bad++; $display("FAIL ill_accept got %b want 1000000", {req_ready, strb()});
        end
        for (int k = 0; k < 2; k++) begin
            nxt();
            req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
            smp();
            n_vec++;
            if ({err, wb_valid, cbusy} !== {2'b10, 8'b0}) begin
                n_bad++; $display("FAIL ill_err k=%0d got err=%b wbv=%b cb=%h",
                                  k, err, wb_valid, cbusy);
            end
        end
    endtask

    task automatic test_reset_mid();
        nxt();
        req(1'b1, 3'd3, 5'd5, 5'd1, 5'd2);
        smp();
        n_vec++;
        if (issue_div !== 1'b1) begin
            n_bad++; $display("FAIL rmid_div got %b want 1", issue_div);
        end
        for (int k = 1; k <= 3; k++) begin
            nxt();
            req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        end
        smp();
        n_vec++;
        if ({fbusy[5], idle} !== 2'b10) begin
            n_bad++; $display("FAIL rmid_pre got fb5=%b idle=%b want 1 0", fbusy[5], idle);
        end
        nxt();
        RST_N = 1'b0;
        #1;
        n_vec++;
        if ({fbusy, idle, wb_valid} !== {32'b0, 2'b10}) begin
            n_bad++; $display("FAIL rmid_clear fb=%h idle=%b wbv=%b", fbusy, idle, wb_valid);
        end
        nxt();
        RST_N = 1'b1;
        for (int k = 5; k <= 14; k++) begin
            if (k > 5) nxt();
            smp();
            n_vec++;
            if (wb_valid !== 1'b0) begin
                n_bad++; $display("FAIL rmid_nowb k=%0d got %b want 0", k, wb_valid);
            end
        end
    endtask

    typedef struct {
        int wbc;
        int op;
        int rd;
    } fl_t;

    function automatic int lat_of(int op);
        case (op)
            0, 1: return 3;
            2: return 2;
            3: return 12;
            4: return 2;
            5: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic test_random();
        fl_t q[$];
        fl_t keep[$];
        int cyc = 0;
        logic eerr = 1'b0;
        for (int i = 0; i < 420; i++) begin
            int op, fd, fs, ft, eop, erd;
            logic v, legal, srcs, stall, coll, dinfl, erdy, acc, ewv;
            logic [31:0] efb, edata;
            logic [7:0] ecb;
            logic [5:0] estb;
            nxt();
            v  = (i < 400) && (($urandom % 4) != 0);
            op = (($urandom % 16) == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
            fd = $urandom % 8;
            fs = $urandom % 8;
            ft = $urandom % 8;
            req(v, 3'(op), 5'(fd), 5'(fs), 5'(ft));
            legal = op < 6;
            srcs  = op inside {0, 1, 2, 3, 5};
            efb = '0; ecb = '0; ewv = 0; eop = 0; erd = 0; coll = 0; dinfl = 0;
            foreach (q[j]) begin
                if (q[j].op == 5) ecb[q[j].rd % 8] = 1'b1;
                else efb[q[j].rd] = 1'b1;
                if (q[j].op == 3) dinfl = 1'b1;
                if (q[j].wbc == cyc) begin
                    ewv = 1'b1; eop = q[j].op; erd = q[j].rd;
                end
                if (legal && q[j].wbc == cyc + lat_of(op)) coll = 1'b1;
            end
            stall = (srcs && (efb[fs] || efb[ft])) ||
                    (legal && ((op == 5) ? ecb[fd % 8] : efb[fd])) ||
                    coll || (op == 3 && dinfl);
            erdy = !stall;
            acc  = v && erdy;
            case (op)
                0: estb = 6'b100000;
                1: estb = 6'b100001;
                2: estb = 6'b010000;
                3: estb = 6'b001000;
                4: estb = 6'b000100;
                5: estb = 6'b000010;
                default: estb = 6'b000000;
            endcase
            if (!acc) estb = 6'b0;
            case (eop)
                0, 1: edata = add_res;
                2: edata = mul_res;
                3: edata = div_res;
                4: edata = itof_res;
                default: edata = {31'b0, cmp_res};
            endcase
            if (!ewv) begin
                edata = '0; erd = 0;
            end
            smp();
            n_vec++;
            if ({req_ready, strb()} !== {erdy, estb}) begin
                n_bad++; $display("FAIL rnd_issue cyc=%0d op=%0d got %b want %b",
                                  cyc, op, {req_ready, strb()}, {erdy, estb});
            end
            n_vec++;
            if ({wb_valid, wb_cond, wb_rd, wb_data} !==
                {ewv, ewv && eop == 5, 5'(erd), edata}) begin
                n_bad++; $display("FAIL rnd_wb cyc=%0d got %b %b %0d %h want %b %0d %h",
                                  cyc, wb_valid, wb_cond, wb_rd, wb_data, ewv, erd, edata);
            end
            n_vec++;
            if ({fbusy, cbusy} !== {efb, ecb}) begin
                n_bad++; $display("FAIL rnd_busy cyc=%0d got %h %h want %h %h",
                                  cyc, fbusy, cbusy, efb, ecb);
            end
            n_vec++;
            if ({idle, err} !== {q.size() == 0, eerr}) begin
                n_bad++; $display("FAIL rnd_flags cyc=%0d got idle=%b err=%b want %b %b",
                                  cyc, idle, err, q.size() == 0, eerr);
            end
            if (acc && legal) q.push_back('{cyc + lat_of(op), op, fd});
            if (acc && !legal) eerr = 1'b1;
            keep.delete();
            foreach (q[j]) if (q[j].wbc > cyc) keep.push_back(q[j]);
            q = keep;
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_raw();
        test_collision();
        test_div();
        test_cmp_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue controller and writeback scheduler for the core's floating-point units: the adder/subtractor, multiplier, divider, int-to-float converter and comparator. The core presents one FP operation per cycle on a valid/ready port. The block checks register hazards with a scoreboard and pulses the issue strobe of the selected unit. It then tracks each operation's fixed latency and delivers exactly one writeback per cycle to the FP register file or condition flags. It sits between the core's decode/execute stage and the FPU IP cores. The core stalls its PC whenever `req_ready` is low.

## Interface
- `LAT_ADD`, 3: add/sub latency in cycles (≥1).
- `LAT_MUL`, 2: multiply latency.
- `LAT_DIV`, 12: divide latency.
- `LAT_ITOF`, 2: int-to-float latency.
- `LAT_CMP`, 1: compare latency.
- `MAX_LAT`, 16: scheduler depth; must be ≥ every `LAT_*`.
- `DIV_PIPELINED`, 0: 0 means the divider accepts only one operation in flight.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operation request.
- `req_ready` out 1: request accepted this cycle when both `req_valid` and `req_ready` are high.
- `req_op` in 3: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 ITOF, 5 CMP; 6–7 illegal.
- `req_fd` in 5: destination FP register; for CMP, `req_fd[2:0]` is the condition flag index.
- `req_fs`, `req_ft` in 5 each: FP source registers; ignored for ITOF.
- `issue_add`, `issue_mul`, `issue_div`, `issue_itof`, `issue_cmp` out 1 each: one-cycle unit start strobes.
- `sub_sel` out 1: high with `issue_add` when the op is SUB.
- `add_res`, `mul_res`, `div_res`, `itof_res` in 32 each: unit results; `cmp_res` in 1.
- `wb_valid` out 1, `wb_cond` out 1, `wb_rd` out 5, `wb_data` out 32: writeback port.
- `fbusy` out 32, `cbusy` out 8: scoreboard, one bit per FP register and per condition flag.
- `idle` out 1: no operation in flight.
- `err` out 1: sticky flag, set by an illegal op.

## Operation
- **Handshake:** accept = `req_valid & req_ready`. In the accept cycle, the unit strobe for `req_op` is high combinationally in that same cycle. No strobe is driven otherwise.
- **Stall conditions.** `req_ready` is low if any of the following holds:
  - (a) `fbusy[req_fs]` or `fbusy[req_ft]` is set and the op is ADD, SUB, MUL, DIV or CMP.
  - (b) The destination bit is set: `fbusy[req_fd]`, or `cbusy[req_fd[2:0]]` for CMP.
  - (c) Writeback slot collision: an already-accepted op has its writeback cycle equal to this op's writeback cycle.
  - (d) The op is DIV, `DIV_PIPELINED`=0, and a DIV is in flight.
- Otherwise `req_ready` is 1, regardless of `req_valid`.
- **Scoreboard:** on accept, the destination bit is set at that edge. It is cleared at the edge that ends the op's writeback cycle. No forwarding: a source equal to `wb_rd` during the writeback cycle still stalls.
- **Schedule:** the block keeps a MAX_LAT-deep shift structure of entries {valid, unit, rd, cond}. Each entry reaches the head exactly L cycles after acceptance and drives the writeback port.
- **Writeback data mux:**
  - Select by the head entry's unit tag.
  - `wb_data` = `{31'b0, cmp_res}` for CMP.
  - `wb_cond` = 1 only for CMP.
  - `wb_rd` = `req_fd` captured at accept.
- **Illegal op (6–7):** accepted if no hazard under (a)–(c), treating the op as having no sources and no destination. No strobe, no writeback; sets `err`.
- `idle` = no valid schedule entry and no DIV in flight.

## Timing
- Accept in cycle T, op latency L → `wb_valid`=1 in cycle T+L only. The unit result is sampled by the register file at the end of cycle T+L.
- Back-to-back accepts are allowed every cycle if there are no hazards.
- Simultaneous cases:
  - A request may be accepted in the same cycle as a writeback, provided it does not hit that cycle's `wb_rd` bit.
  - A writeback clearing bit X and a new accept setting bit X cannot occur in the same cycle, because (b) blocks it.
- **Reset:** `RST_N` low clears all state immediately, including mid-operation; in-flight ops are discarded. While reset is asserted and after release, outputs hold their reset values until the first accept:
  - `wb_valid`=0, `wb_cond`=0, `wb_rd`=0, `wb_data`=0.
  - `fbusy`=0, `cbusy`=0, `idle`=1, `err`=0.
  - `issue_*`=0, `sub_sel`=0.
  - `req_ready`=1 once out of reset.
- After the DIV writeback cycle, a new DIV may be accepted in the next cycle (`DIV_PIPELINED`=0).

## Test plan
- **Basic ADD:** reset, then ADD fd=3 fs=1 ft=2 accepted at T. `issue_add`=1 and `sub_sel`=0 at T. `fbusy[3]`=1 over T+1..T+3. `wb_valid`, `wb_rd`=3, `wb_data`=`add_res` at T+3. `fbusy[3]`=0 at T+4.
- **RAW stall:** MUL fd=4 at T, then ADD fs=4 held valid. `req_ready`=0 through T+2; ADD accepted at T+3; its writeback at T+6.
- **Slot collision:** ADD at T (wb T+3), then MUL requested at T+1 (wb T+3). MUL is stalled one cycle, accepted at T+2, and writes back at T+4. ADD writes back at T+3.
- **Divider occupancy:** DIV fd=5 at T, second DIV fd=6 requested at T+1. `req_ready`=0 until T+13. First DIV writes back at T+12; second DIV is accepted at T+13 and writes back at T+25.
- **CMP to condition flag:** CMP fd=2 (flag 2) at T → `cbusy[2]`=1 at T+1; `wb_cond`=1, `wb_rd[2:0]`=2, `wb_data[0]`=`cmp_res` at T+1. Separately, op=7 is accepted with no strobe and no writeback; `err`=1 and stays 1.
- **Reset mid-operation:** DIV in flight, `RST_N` pulsed low at T+4. `fbusy`=0, `idle`=1, `wb_valid`=0 immediately; no writeback occurs at T+12.
